dmem_wb_master: RTL and testbench
=================================

Name: dmem_wb_master

Overview:
- Data-memory bus master between the MIPS core's load/store unit and the Wishbone data bus.
- The bus serves the SSRAM slave and the other peripherals.
- Converts single-cycle CPU byte/half/word requests into Wishbone classic cycles with byte-lane steering, sign/zero extension, misalignment detection and a bus timeout.
- Stalls the pipeline until the slave acknowledges. Tolerates slaves that hold ack high until cyc/stb drop.

Parameters:
- TIMEOUT, 255, max cycles in BUS state waiting for ack_i before aborting (1..255).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  CPU memory request valid (held until stall_o low)
- we_i  in  1  1=store, 0=load
- size_i  in  2  00=byte, 01=half, 10=word, 11=invalid
- sign_i  in  1  loads only: 1=sign-extend, 0=zero-extend
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified
- rdata_o  out  32  load result, extended, valid when done_o=1
- stall_o  out  1  combinational: req_i & ~done_o
- done_o  out  1  one-cycle pulse; request complete (success or error)
- err_o  out  1  one-cycle pulse with done_o: misaligned, invalid size or timeout
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe (always equals cyc_o)
- we_o  out  1  Wishbone write enable
- sel_o  out  4  byte lanes, bit n = dat[8n+7:8n]
- adr_o  out  32  word address, {addr[31:2],2'b00}
- dat_o  out  32  write data, lane-replicated
- dat_i  in  32  read data from slave
- ack_i  in  1  slave acknowledge

Behaviour:
- Reset (rst_i=1 at a clock edge, any state): state=IDLE; counter=0. cyc_o, stb_o, we_o, done_o, err_o = 0; sel_o=0; adr_o=0; dat_o=0; rdata_o=0. Any in-flight cycle is abandoned with no done_o.
- Endianness is little: the lane is addr_i[1:0].
- sel_o encoding:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1]?1100:0011
  - word: 1111
- dat_o encoding: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extraction: select the lane(s) by addr[1:0] from dat_i, then sign- or zero-extend per sign_i. A word load ignores sign_i.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- States:
  - IDLE:
    - If req_i & misaligned: go ERR; no bus activity.
    - If req_i & aligned & ~ack_i: latch we/size/sign/addr lane/sel/adr/dat; cyc=stb=1; counter=0; go BUS.
    - If ack_i is still high: stay IDLE, because the previous slave has not released.
  - BUS:
    - If ack_i: cyc=stb=0; rdata_o=extracted dat_i (loads only; stores leave rdata_o unchanged); done_o=1; go RELEASE.
    - Else if counter==TIMEOUT-1: cyc=stb=0; rdata_o=0; done_o=err_o=1; go RELEASE.
    - Else counter++.
  - RELEASE: done_o/err_o drop to 0. Stay until ack_i==0, then go IDLE. New req_i is stalled here (stall_o=1).
  - ERR: done_o=err_o=1 for exactly one cycle; rdata_o=0; go IDLE.
- Latency:
  - First bus cycle (cyc_o high) starts 1 cycle after req_i is sampled in IDLE.
  - done_o is asserted the cycle after ack_i is sampled.
  - Back-to-back requests cost at least one RELEASE cycle.
- Request fields are captured at IDLE acceptance; changes to CPU inputs during BUS are ignored.
- ack_i arriving while in IDLE/ERR is ignored.
- ack_i and the timeout reaching their limit in the same cycle: ack wins, no error.

Decomposition:
- Package dmem_wb_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD
  - state enum IDLE/BUS/RELEASE/ERR (2 bits)
  - default TIMEOUT
- One combinational sub-module, wb_lane_steer, takes size/addr[1:0]/sign/wdata/dat_i and produces sel, replicated wdata, extended rdata and the misaligned flag. The FSM, counter and registers stay in the top.

Test Plan:
- Word store at 0x0000_0104, data 0xDEADBEEF, slave ack after 3 cycles (held until stb drops) -> adr_o=0x104, sel_o=1111, dat_o=0xDEADBEEF, we_o=1. done_o pulses one cycle after ack; RELEASE lasts until ack falls.
- Byte load at 0x0000_0103, sign_i=1, dat_i=0x80112233 -> sel_o=1000, rdata_o=0xFFFFFF80. Repeat with sign_i=0 -> rdata_o=0x00000080.
- Half store at 0x0000_0002, wdata=0x0000ABCD -> sel_o=1100, dat_o=0xABCDABCD. Half load at addr 0x2, dat_i=0x8001_1234, sign_i=1 -> rdata_o=0xFFFF8001.
- Word load at 0x0000_0006 -> no cyc_o; done_o=err_o=1 next cycle; rdata_o=0. Same for size_i=11.
- Slave never acks, TIMEOUT=4 -> cyc_o high exactly 4 cycles, then done_o=err_o=1, rdata_o=0; next request proceeds normally.
- rst_i asserted during BUS -> next cycle cyc_o=stb_o=0, done_o=0, state IDLE. Back-to-back loads with the slave holding ack 1 extra cycle -> second cyc_o not raised until ack_i low.

Source files
------------

// File: rtl/dmem_wb_pkg.sv
// Shared encodings for the data-memory Wishbone master: access sizes, FSM states and
// the default bus timeout.
package dmem_wb_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS     = 2'd1,
      RELEASE = 2'd2,
      ERR     = 2'd3
   } state_e;

   localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_lane_steer.sv
// Byte-lane steering for little-endian accesses: store lane select and replication,
// load lane extraction with sign/zero extension, and misalignment detection.
module wb_lane_steer
   import dmem_wb_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic        sign_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdat_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdat_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v       = rdat_i[{lane_i, 3'b000} +: 8];
      half_v       = lane_i[1] ? rdat_i[31:16] : rdat_i[15:0];
      sel_o        = 4'b0000;
      wdat_o       = '0;
      rdata_o      = '0;
      misaligned_o = 1'b0;
      unique case (size_i)
         SZ_BYTE: begin
            sel_o   = 4'b0001 << lane_i;
            wdat_o  = {4{wdata_i[7:0]}};
            rdata_o = {{24{sign_i & byte_v[7]}}, byte_v};
         end
         SZ_HALF: begin
            sel_o        = lane_i[1] ? 4'b1100 : 4'b0011;
            wdat_o       = {2{wdata_i[15:0]}};
            rdata_o      = {{16{sign_i & half_v[15]}}, half_v};
            misaligned_o = lane_i[0];
         end
         SZ_WORD: begin
            sel_o        = 4'b1111;
            wdat_o       = wdata_i;
            rdata_o      = rdat_i;
            misaligned_o = |lane_i;
         end
         default: misaligned_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_wb_master.sv
// Load/store unit to Wishbone classic bridge: one bus cycle per CPU request, with
// pipeline stall, timeout abort and tolerance of slaves that hold ack after stb drops.
module dmem_wb_master
   import dmem_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        done_o,
   output logic        err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [3:0]  sel_o,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [1:0]        lane_q, lane_d;
   logic              cyc_q, cyc_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [1:0]        st_size;
   logic [1:0]        st_lane;
   logic              st_sign;
   logic [3:0]        st_sel;
   logic [31:0]       st_wdat;
   logic [31:0]       st_rdata;
   logic              st_misaligned;

   // Live CPU fields steer while idle; captured fields steer the load return.
   always_comb begin
      if (state_q == IDLE) begin
         st_size = size_i;
         st_lane = addr_i[1:0];
         st_sign = sign_i;
      end else begin
         st_size = size_q;
         st_lane = lane_q;
         st_sign = sign_q;
      end
   end

   wb_lane_steer u_lane_steer (
      .size_i       (st_size),
      .lane_i       (st_lane),
      .sign_i       (st_sign),
      .wdata_i      (wdata_i),
      .rdat_i       (dat_i),
      .sel_o        (st_sel),
      .wdat_o       (st_wdat),
      .rdata_o      (st_rdata),
      .misaligned_o (st_misaligned)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      sign_d  = sign_q;
      lane_d  = lane_q;
      cyc_d   = cyc_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               if (st_misaligned) begin
                  state_d = ERR;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (!ack_i) begin
                  state_d = BUS;
                  we_d    = we_i;
                  size_d  = size_i;
                  sign_d  = sign_i;
                  lane_d  = addr_i[1:0];
                  sel_d   = st_sel;
                  adr_d   = {addr_i[31:2], 2'b00};
                  dat_d   = st_wdat;
                  cyc_d   = 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         BUS: begin
            // Ack takes priority over an expiring timeout.
            if (ack_i) begin
               state_d = RELEASE;
               cyc_d   = 1'b0;
               done_d  = 1'b1;
               if (!we_q) rdata_d = st_rdata;
            end else if (cnt_q == CntLast) begin
               state_d = RELEASE;
               cyc_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!ack_i) state_d = IDLE;
         end
         ERR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         lane_q  <= 2'b00;
         cyc_q   <= 1'b0;
         sel_q   <= 4'b0000;
         adr_q   <= '0;
         dat_q   <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         lane_q  <= lane_d;
         cyc_q   <= cyc_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign stall_o = req_i & ~done_q;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;
   assign cyc_o   = cyc_q;
   assign stb_o   = cyc_q;
   assign we_o    = we_q;
   assign sel_o   = sel_q;
   assign adr_o   = adr_q;
   assign dat_o   = dat_q;

endmodule

// File: tb/tb_dmem_wb_master.sv
// Randomized bench for dmem_wb_master against a behavioural model of the access rules
// and a slave that acks after a chosen delay and may hold ack after stb drops.
module tb_dmem_wb_master;

   localparam int unsigned TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        sign_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        done_o;
   logic        err_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [3:0]  sel_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_rdata;
   int          ack_left;

   dmem_wb_master #(
      .TIMEOUT (TO),
      .CNT_W   (8)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .we_i    (we_i),
      .size_i  (size_i),
      .sign_i  (sign_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .stall_o (stall_o),
      .done_o  (done_o),
      .err_o   (err_o),
      .cyc_o   (cyc_o),
      .stb_o   (stb_o),
      .we_o    (we_o),
      .sel_o   (sel_o),
      .adr_o   (adr_o),
      .dat_o   (dat_o),
      .dat_i   (dat_i),
      .ack_i   (ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: access rules written as plain arithmetic.
   function automatic bit m_bad(input int size, input int lane);
      return (size == 3) || (size == 1 && (lane % 2) != 0) || (size == 2 && lane != 0);
   endfunction

   function automatic logic [3:0] m_sel(input int size, input int lane);
      if (size == 0) return 4'(1 << lane);
      if (size == 1) return (lane >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_dat(input int size, input logic [31:0] w);
      if (size == 0) return (w & 32'h0000_00FF) * 32'h0101_0101;
      if (size == 1) return (w & 32'h0000_FFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input int size, input int lane, input bit sign,
                                          input logic [31:0] d);
      int     nb;
      int     off;
      longint v;
      if (size == 2) return d;
      nb  = (size == 0) ? 8 : 16;
      off = (size == 0) ? lane * 8 : ((lane >= 2) ? 16 : 0);
      v   = longint'(d >> off) & ((longint'(1) << nb) - 1);
      if (sign && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
      return 32'(v);
   endfunction

   task automatic scramble();
      we_i    = 1'($urandom);
      size_i  = 2'($urandom);
      sign_i  = 1'($urandom);
      addr_i  = $urandom;
      wdata_i = $urandom;
   endtask

   task automatic do_req(input bit we, input int size, input bit sign, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_dly, input int hold,
                         input logic [31:0] rd);
      int          lane;
      int          k;
      int          k_exp;
      bit          got;
      bit          tout;
      logic [31:0] exp_rd;
      lane = int'(addr[1:0]);
      @(negedge clk_i);
      check_eq("done_pulse", 32'(done_o), 32'd0);
      req_i   = 1'b1;
      we_i    = we;
      size_i  = 2'(size);
      sign_i  = sign;
      addr_i  = addr;
      wdata_i = wdata;
      if (ack_left > 0) begin
         repeat (ack_left) begin
            @(negedge clk_i);
            check_eq("rel_cyc", 32'(cyc_o), 32'd0);
            check_eq("rel_stall", 32'(stall_o), 32'd1);
         end
         ack_i    = 1'b0;
         ack_left = 0;
         @(negedge clk_i);
         check_eq("rel_gap_cyc", 32'(cyc_o), 32'd0);
      end
      if (m_bad(size, lane)) begin
         @(negedge clk_i);
         check_eq("bad_cyc", 32'(cyc_o), 32'd0);
         check_eq("bad_done", 32'(done_o), 32'd1);
         check_eq("bad_err", 32'(err_o), 32'd1);
         check_eq("bad_rdata", rdata_o, 32'd0);
         last_rdata = '0;
         req_i      = 1'b0;
         @(negedge clk_i);
         check_eq("bad_pulse", 32'(done_o), 32'd0);
         return;
      end
      @(negedge clk_i);
      check_eq("start_cyc", 32'(cyc_o), 32'd1);
      check_eq("start_stb", 32'(stb_o), 32'd1);
      check_eq("start_we", 32'(we_o), 32'(we));
      check_eq("start_sel", 32'(sel_o), 32'(m_sel(size, lane)));
      check_eq("start_adr", adr_o, addr & 32'hFFFF_FFFC);
      if (we) check_eq("start_dat", dat_o, m_dat(size, wdata));
      check_eq("bus_stall", 32'(stall_o), 32'd1);
      scramble();
      k   = 0;
      got = 1'b0;
      while (!got && k <= int'(TO) + 2) begin
         if (k == ack_dly) begin
            ack_i = 1'b1;
            dat_i = rd;
         end
         @(negedge clk_i);
         k++;
         if (done_o) got = 1'b1;
         else begin
            check_eq("bus_cyc", 32'(cyc_o), 32'd1);
            check_eq("bus_adr", adr_o, addr & 32'hFFFF_FFFC);
         end
      end
      tout  = (ack_dly >= int'(TO));
      k_exp = tout ? int'(TO) : ack_dly + 1;
      check_eq("done_seen", 32'(got), 32'd1);
      check_eq("done_lat", 32'(k), 32'(k_exp));
      check_eq("done_err", 32'(err_o), 32'(tout));
      check_eq("done_cyc", 32'(cyc_o), 32'd0);
      check_eq("done_stall", 32'(stall_o), 32'd0);
      if (tout) exp_rd = '0;
      else if (we) exp_rd = last_rdata;
      else exp_rd = m_load(size, lane, sign, rd);
      check_eq("done_rdata", rdata_o, exp_rd);
      last_rdata = exp_rd;
      req_i      = 1'b0;
      dat_i      = $urandom;
      if (!tout) begin
         if (hold == 0) ack_i = 1'b0;
         else ack_left = hold;
      end
   endtask

   task automatic reset_in_bus();
      @(negedge clk_i);
      req_i  = 1'b1;
      we_i   = 1'b0;
      size_i = 2'd2;
      sign_i = 1'b0;
      addr_i = 32'h0000_0040;
      @(negedge clk_i);
      check_eq("rst_pre_cyc", 32'(cyc_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check_eq("rst_cyc", 32'(cyc_o), 32'd0);
      check_eq("rst_stb", 32'(stb_o), 32'd0);
      check_eq("rst_done", 32'(done_o), 32'd0);
      check_eq("rst_sel", 32'(sel_o), 32'd0);
      check_eq("rst_adr", adr_o, 32'd0);
      rst_i      = 1'b0;
      req_i      = 1'b0;
      last_rdata = '0;
      ack_left   = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_i      = 1'b1;
      req_i      = 1'b0;
      we_i       = 1'b0;
      size_i     = 2'd0;
      sign_i     = 1'b0;
      addr_i     = '0;
      wdata_i    = '0;
      dat_i      = '0;
      ack_i      = 1'b0;
      last_rdata = '0;
      ack_left   = 0;
      repeat (3) @(negedge clk_i);
      check_eq("reset_cyc", 32'(cyc_o), 32'd0);
      check_eq("reset_we", 32'(we_o), 32'd0);
      check_eq("reset_done", 32'(done_o), 32'd0);
      check_eq("reset_err", 32'(err_o), 32'd0);
      check_eq("reset_sel", 32'(sel_o), 32'd0);
      check_eq("reset_adr", adr_o, 32'd0);
      check_eq("reset_dat", dat_o, 32'd0);
      check_eq("reset_rdata", rdata_o, 32'd0);
      rst_i = 1'b0;

      do_req(1'b1, 2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 2, 1, 32'h0);
      do_req(1'b0, 0, 1'b1, 32'h0000_0103, 32'h0, 0, 0, 32'h8011_2233);
      check_eq("byte_sx", rdata_o, 32'hFFFF_FF80);
      do_req(1'b0, 0, 1'b0, 32'h0000_0103, 32'h0, 1, 0, 32'h8011_2233);
      check_eq("byte_zx", rdata_o, 32'h0000_0080);
      do_req(1'b1, 1, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 0, 0, 32'h0);
      do_req(1'b0, 1, 1'b1, 32'h0000_0002, 32'h0, 1, 0, 32'h8001_1234);
      check_eq("half_sx", rdata_o, 32'hFFFF_8001);
      do_req(1'b0, 2, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h1234_5678);
      do_req(1'b0, 3, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'h1234_5678);
      do_req(1'b0, 2, 1'b0, 32'h0000_0010, 32'h0, 99, 0, 32'h0);
      do_req(1'b0, 2, 1'b0, 32'h0000_0014, 32'h0, 0, 0, 32'hCAFE_F00D);
      do_req(1'b0, 2, 1'b0, 32'h0000_0018, 32'h0, int'(TO) - 1, 0, 32'h0BAD_CAFE);
      reset_in_bus();
      do_req(1'b0, 2, 1'b0, 32'h0000_0020, 32'h0, 0, 1, 32'h1111_2222);
      do_req(1'b0, 0, 1'b0, 32'h0000_0021, 32'h0, 0, 2, 32'h3344_5566);

      for (int i = 0; i < 80; i++) begin
         int          sz;
         int          ln;
         logic [31:0] a;
         sz = int'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 8) ln = (sz == 0) ? int'($urandom_range(0, 3)) :
                                            (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
         else ln = int'($urandom_range(0, 3));
         a = {$urandom, 2'b00};
         a[1:0] = 2'(ln);
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), $urandom);
      end

      @(negedge clk_i);
      ack_i = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
